cp0_exc_unit: RTL and testbench
===============================

# cp0_exc_unit

Coprocessor-0 register and exception-control block for the single-cycle MIPS core. It sits beside the register file on the write-back side. It consumes the register file's second read port (Qb) for `mtc0`, and supplies `mfc0` data that is muxed into the register file's write data (D). It owns Status/Cause/EPC, synchronises the external interrupt, and selects the next-PC source on exception entry and `eret`.

## Interface
Parameters:
- EXC_VECTOR, 32'h0000_0008, handler entry address, driven on ExcVector

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Clrn  in  1  asynchronous active-low reset
- Intr  in  1  external interrupt request, asynchronous to Clk
- Pc  in  32  PC of the instruction in execution
- PcNext  in  32  PC of the following instruction
- Mtc0  in  1  write CP0 register Rd with Wdata (Wdata = register file Qb)
- Rd  in  5  CP0 register number: 12 Status, 13 Cause, 14 EPC
- Wdata  in  32  mtc0 write data
- Eret  in  1  return from exception
- Syscall  in  1  syscall exception this cycle
- Unimpl  in  1  unimplemented-instruction exception this cycle
- Ovr  in  1  arithmetic overflow exception this cycle
- Rdata  out  32  combinational read of register Rd (mfc0 path to register file D)
- Status  out  32  Status register
- Cause  out  32  Cause register
- Epc  out  32  EPC register
- ExcTaken  out  1  exception accepted this cycle; kills register file We and memory write for the current instruction
- PcSel  out  2  0 = PcNext, 1 = ExcVector, 2 = Epc
- ExcVector  out  32  constant EXC_VECTOR
- IntAck  out  1  one-cycle pulse when an interrupt is taken

## Operation
- Status bit layout:
  - [0] IE: interrupt enable
  - [1] syscall enable
  - [2] unimpl enable
  - [3] overflow enable
  - [4] EXL: in-handler flag
  - [31:5] read as 0
- Cause: [6:2] ExcCode; all other bits read 0. Cause is read-only to mtc0.
- ExcCode values: 0 interrupt, 8 syscall, 10 unimplemented, 12 overflow.
- EPC holds the 32-bit resume PC. It is writable by mtc0.
- Interrupt path:
  - Intr passes through a 2-flop synchroniser, then a third flop for rising-edge detection.
  - A synchronised rising edge sets the sticky IntPend flag.
  - IntPend clears only when the interrupt is taken.
  - IntPend is not visible in Cause.
- Two-state control derived from EXL: RUN (EXL=0) and HANDLER (EXL=1).
- In RUN, candidate causes are ANDed with their enable bits. Fixed priority: Ovr > Unimpl > Syscall > interrupt (IntPend & IE).
- The winning cause asserts ExcTaken and PcSel=1 combinationally. On the clock edge:
  - Cause[6:2] is loaded with the winner's code.
  - EXL is set to 1; the state becomes HANDLER.
  - EPC is loaded with Pc for a synchronous exception, or PcNext for an interrupt.
  - For an interrupt: IntAck=1 that cycle and IntPend is cleared.
- In HANDLER, all exceptions and interrupts are ignored: ExcTaken=0. IntPend keeps accumulating.
- Eret (in either state, no exception taken) sets PcSel=2 and clears EXL on the edge, giving RUN.
- Mtc0 with Rd=12 writes Status[4:0]; with Rd=14 writes EPC; any other Rd is ignored.
- Rdata returns Status, Cause or EPC for Rd 12/13/14, else 32'h0.
- Simultaneous events:
  - Exception with Mtc0 or Eret: the exception wins; the Mtc0 write and the Eret are suppressed.
  - Mtc0 to Status with Eret: the Mtc0 value is written first, then EXL is forced to 0.
  - Intr edge on the same cycle an interrupt is taken: IntPend stays set.

## Timing
- Reset (Clrn=0, immediate):
  - Status, Cause, EPC, IntPend and all synchroniser flops = 0.
  - Rdata = 0; ExcTaken = 0; IntAck = 0; PcSel = 0.
- Reset mid-handler returns to RUN with all exceptions masked.
- ExcTaken, PcSel and Rdata are combinational with zero latency. Register updates are visible the cycle after the edge.
- Interrupt latency: Intr rising shortly before edge k gives IntPend=1 after edge k+3. With IE=1, EXL=0 and no higher-priority exception, ExcTaken is asserted in the cycle following edge k+3.
- IntAck is exactly one Clk wide per taken interrupt.

## Test plan
- Reset, then read Rd=12/13/14 -> Rdata = 0 each; PcSel=0; ExcTaken=0.
- Mtc0 Rd=12 Wdata=32'hFFFF_FFFF -> Status reads 32'h0000_001F. Mtc0 Rd=13 Wdata=32'h7C -> Cause stays 0.
- Status=32'h0F, Pc=32'h40, Ovr=Syscall=1 -> ExcTaken=1, PcSel=1 in the same cycle; next cycle Cause=32'h30, EPC=32'h40, Status=32'h1F.
- In HANDLER, Syscall=1 -> ExcTaken=0, no register change. Then Eret -> PcSel=2; next cycle Status=32'h0F.
- Status=32'h01, PcNext=32'h100, pulse Intr -> ExcTaken three edges later; IntAck one cycle; EPC=32'h100; Cause=0; Status=32'h11.
- Intr pulsed with IE=0 -> IntPend held. Mtc0 Status=32'h01 -> interrupt taken the next cycle. Clrn asserted mid-handler -> all registers 0 immediately.

Source files
------------

// File: rtl/cp0_exc_unit.sv
// cp0_exc_unit
//   Coprocessor-0 register and exception-control block for the single-cycle MIPS core.
//   Owns Status/Cause/EPC, synchronises the external interrupt, arbitrates exception
//   causes and selects the next-PC source on exception entry and eret.
//
// Ports
//   i_clk          clock, all state updates on the rising edge
//   i_clrn         asynchronous active-low reset
//   i_intr         external interrupt request, asynchronous to i_clk
//   i_pc           PC of the instruction in execution
//   i_pc_next      PC of the following instruction
//   i_mtc0         write CP0 register i_rd with i_wdata
//   i_rd           CP0 register number: 12 Status, 13 Cause, 14 EPC
//   i_wdata        mtc0 write data (register file Qb)
//   i_eret         return from exception
//   i_syscall      syscall exception this cycle
//   i_unimpl       unimplemented-instruction exception this cycle
//   i_ovr          arithmetic overflow exception this cycle
//   o_rdata        combinational read of register i_rd (mfc0 data)
//   o_status       Status register
//   o_cause        Cause register
//   o_epc          EPC register
//   o_exc_taken    exception accepted this cycle (kills register file / memory writes)
//   o_pc_sel       0 = PcNext, 1 = exception vector, 2 = EPC
//   o_exc_vector   constant handler entry address
//   o_int_ack      one-cycle pulse when an interrupt is taken
module cp0_exc_unit #(
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0008
) (
   input  logic        i_clk,
   input  logic        i_clrn,
   input  logic        i_intr,
   input  logic [31:0] i_pc,
   input  logic [31:0] i_pc_next,
   input  logic        i_mtc0,
   input  logic [4:0]  i_rd,
   input  logic [31:0] i_wdata,
   input  logic        i_eret,
   input  logic        i_syscall,
   input  logic        i_unimpl,
   input  logic        i_ovr,
   output logic [31:0] o_rdata,
   output logic [31:0] o_status,
   output logic [31:0] o_cause,
   output logic [31:0] o_epc,
   output logic        o_exc_taken,
   output logic [1:0]  o_pc_sel,
   output logic [31:0] o_exc_vector,
   output logic        o_int_ack
);

   typedef enum logic {StRun, StHandler} state_e;

   localparam logic [4:0] CodeInt    = 5'd0;
   localparam logic [4:0] CodeSys    = 5'd8;
   localparam logic [4:0] CodeUnimpl = 5'd10;
   localparam logic [4:0] CodeOvr    = 5'd12;

   logic [4:0]  r_status;   // [4] EXL, [3:1] cause enables, [0] IE
   logic [4:0]  r_exc_code;
   logic [31:0] r_epc;
   logic        r_sync1;
   logic        r_sync2;
   logic        r_sync3;
   logic        r_int_edge;
   logic        r_int_pend;

   state_e      w_state;
   logic        w_exc;
   logic        w_int_win;
   logic [4:0]  w_code;

   // The control state is nothing more than the EXL bit.
   assign w_state = r_status[4] ? StHandler : StRun;

   // Fixed-priority arbitration of enabled causes; nothing is taken inside the handler.
   always_comb begin
      w_exc     = 1'b0;
      w_int_win = 1'b0;
      w_code    = CodeInt;
      if (w_state == StRun) begin
         if (i_ovr && r_status[3]) begin
            w_exc  = 1'b1;
            w_code = CodeOvr;
         end else if (i_unimpl && r_status[2]) begin
            w_exc  = 1'b1;
            w_code = CodeUnimpl;
         end else if (i_syscall && r_status[1]) begin
            w_exc  = 1'b1;
            w_code = CodeSys;
         end else if (r_int_pend && r_status[0]) begin
            w_exc     = 1'b1;
            w_int_win = 1'b1;
            w_code    = CodeInt;
         end
      end
   end

   always_comb begin
      o_pc_sel = 2'd0;
      if (w_exc) begin
         o_pc_sel = 2'd1;
      end else if (i_eret) begin
         o_pc_sel = 2'd2;
      end
   end

   always_comb begin
      unique case (i_rd)
         5'd12:   o_rdata = o_status;
         5'd13:   o_rdata = o_cause;
         5'd14:   o_rdata = o_epc;
         default: o_rdata = 32'h0;
      endcase
   end

   assign o_status     = {27'h0, r_status};
   assign o_cause      = {25'h0, r_exc_code, 2'b00};
   assign o_epc        = r_epc;
   assign o_exc_taken  = w_exc;
   assign o_int_ack    = w_int_win;
   assign o_exc_vector = EXC_VECTOR;

   // Interrupt synchroniser and edge detector; the registered edge sets IntPend one
   // edge later, and a new edge on the same cycle as the take keeps it set.
   always_ff @(posedge i_clk or negedge i_clrn) begin
      if (!i_clrn) begin
         r_sync1    <= 1'b0;
         r_sync2    <= 1'b0;
         r_sync3    <= 1'b0;
         r_int_edge <= 1'b0;
         r_int_pend <= 1'b0;
      end else begin
         r_sync1    <= i_intr;
         r_sync2    <= r_sync1;
         r_sync3    <= r_sync2;
         r_int_edge <= r_sync2 & ~r_sync3;
         r_int_pend <= r_int_edge | (r_int_pend & ~w_int_win);
      end
   end

   // Architectural registers. An accepted exception suppresses mtc0 and eret.
   always_ff @(posedge i_clk or negedge i_clrn) begin
      if (!i_clrn) begin
         r_status   <= 5'h0;
         r_exc_code <= 5'h0;
         r_epc      <= 32'h0;
      end else if (w_exc) begin
         r_exc_code  <= w_code;
         r_status[4] <= 1'b1;
         r_epc       <= w_int_win ? i_pc_next : i_pc;
      end else begin
         if (i_mtc0 && (i_rd == 5'd14)) begin
            r_epc <= i_wdata;
         end
         // eret after the mtc0 value so EXL always ends up cleared.
         if (i_mtc0 && (i_rd == 5'd12)) begin
            r_status <= {i_wdata[4] & ~i_eret, i_wdata[3:0]};
         end else if (i_eret) begin
            r_status[4] <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cp0_exc_unit.sv
module tb_cp0_exc_unit;

   logic        clk = 1'b0;
   logic        clrn;
   logic        intr;
   logic [31:0] pc;
   logic [31:0] pc_next;
   logic        mtc0;
   logic [4:0]  rd;
   logic [31:0] wdata;
   logic        eret;
   logic        syscall;
   logic        unimpl;
   logic        ovr;
   logic [31:0] rdata;
   logic [31:0] status;
   logic [31:0] cause;
   logic [31:0] epc;
   logic        exc_taken;
   logic [1:0]  pc_sel;
   logic [31:0] exc_vector;
   logic        int_ack;

   int n_asserts = 0;
   int n_fails   = 0;

   // Reference model state
   logic [31:0] m_status;
   logic [31:0] m_cause;
   logic [31:0] m_epc;
   bit          m_pend;
   bit          s1, s2, s3, s4;  // Intr samples at the last four edges, s1 most recent

   cp0_exc_unit #(.EXC_VECTOR(32'h0000_0008)) dut (
      .i_clk       (clk),
      .i_clrn      (clrn),
      .i_intr      (intr),
      .i_pc        (pc),
      .i_pc_next   (pc_next),
      .i_mtc0      (mtc0),
      .i_rd        (rd),
      .i_wdata     (wdata),
      .i_eret      (eret),
      .i_syscall   (syscall),
      .i_unimpl    (unimpl),
      .i_ovr       (ovr),
      .o_rdata     (rdata),
      .o_status    (status),
      .o_cause     (cause),
      .o_epc       (epc),
      .o_exc_taken (exc_taken),
      .o_pc_sel    (pc_sel),
      .o_exc_vector(exc_vector),
      .o_int_ack   (int_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_status = 32'h0;
      m_cause  = 32'h0;
      m_epc    = 32'h0;
      m_pend   = 1'b0;
      s1 = 1'b0; s2 = 1'b0; s3 = 1'b0; s4 = 1'b0;
   endtask

   task automatic idle_inputs();
      mtc0 = 1'b0; eret = 1'b0; syscall = 1'b0; unimpl = 1'b0; ovr = 1'b0;
      wdata = 32'h0;
   endtask

   // Called at a falling edge with inputs applied: checks all outputs against the model,
   // crosses the rising edge, advances the model, returns at the next falling edge.
   task automatic step();
      int          code;
      bit          taken;
      bit          rise;
      logic [31:0] exp_rd;
      logic [31:0] exp_sel;
      #1;
      code = -1;
      if (m_status[4] == 1'b0) begin
         if (ovr && m_status[3])          code = 12;
         else if (unimpl && m_status[2])  code = 10;
         else if (syscall && m_status[1]) code = 8;
         else if (m_pend && m_status[0])  code = 0;
      end
      taken = (code >= 0);
      case (rd)
         5'd12:   exp_rd = m_status;
         5'd13:   exp_rd = m_cause;
         5'd14:   exp_rd = m_epc;
         default: exp_rd = 32'h0;
      endcase
      exp_sel = taken ? 32'd1 : (eret ? 32'd2 : 32'd0);
      chk("exc_taken", 32'(exc_taken), 32'(taken));
      chk("pc_sel", 32'(pc_sel), exp_sel);
      chk("int_ack", 32'(int_ack), 32'(taken && code == 0));
      chk("rdata", rdata, exp_rd);
      chk("status", status, m_status);
      chk("cause", cause, m_cause);
      chk("epc", epc, m_epc);
      chk("exc_vector", exc_vector, 32'h8);
      @(posedge clk);
      // A rising Intr sampled three edges ago raises the pending flag now.
      rise   = s3 && !s4;
      m_pend = (m_pend && !(taken && code == 0)) || rise;
      s4 = s3; s3 = s2; s2 = s1; s1 = intr;
      if (taken) begin
         m_cause  = 32'(code) * 4;
         m_status = m_status | 32'h10;
         m_epc    = (code == 0) ? pc_next : pc;
      end else begin
         if (mtc0 && rd == 5'd12) m_status = wdata & 32'h1F;
         if (mtc0 && rd == 5'd14) m_epc = wdata;
         if (eret) m_status = m_status & ~32'h10;
      end
      @(negedge clk);
   endtask

   initial begin
      int first_take;
      int acks;
      clrn = 1'b0; intr = 1'b0; pc = 32'h0; pc_next = 32'h0; rd = 5'd0;
      idle_inputs();
      model_reset();

      // Reset state
      for (int r = 12; r <= 14; r++) begin
         rd = 5'(r);
         #1 chk("reset_rdata", rdata, 32'h0);
      end
      chk("reset_pc_sel", 32'(pc_sel), 32'h0);
      chk("reset_exc_taken", 32'(exc_taken), 32'h0);
      chk("reset_int_ack", 32'(int_ack), 32'h0);
      @(negedge clk); clrn = 1'b1;
      step();

      // Status write masks to 5 bits; Cause ignores mtc0
      mtc0 = 1'b1; rd = 5'd12; wdata = 32'hFFFF_FFFF; step();
      idle_inputs(); #1 chk("status_mask", status, 32'h1F);
      mtc0 = 1'b1; rd = 5'd13; wdata = 32'h7C; step();
      idle_inputs(); #1 chk("cause_readonly", cause, 32'h0);
      mtc0 = 1'b1; rd = 5'd12; wdata = 32'h0F; step();

      // Overflow beats syscall
      idle_inputs(); pc = 32'h40; ovr = 1'b1; syscall = 1'b1; rd = 5'd13; step();
      idle_inputs();
      #1 chk("ovr_cause", cause, 32'h30);
      chk("ovr_epc", epc, 32'h40);
      chk("ovr_status", status, 32'h1F);

      // Ignored in handler, then eret
      syscall = 1'b1; step();
      idle_inputs(); eret = 1'b1; step();
      idle_inputs(); #1 chk("eret_status", status, 32'h0F);

      // Interrupt latency, ack width, EPC = PcNext
      mtc0 = 1'b1; rd = 5'd12; wdata = 32'h01; step();
      idle_inputs(); pc_next = 32'h100; pc = 32'h0FC;
      first_take = -1; acks = 0;
      for (int i = 0; i < 8; i++) begin
         if (i == 0) intr = 1'b1;
         if (i == 3) intr = 1'b0;
         #1;
         if (exc_taken && first_take < 0) first_take = i;
         if (int_ack) acks++;
         step();
      end
      chk("int_latency", 32'(first_take), 32'd4);
      chk("int_ack_count", 32'(acks), 32'd1);
      chk("int_epc", epc, 32'h100);
      chk("int_cause", cause, 32'h0);
      chk("int_status", status, 32'h11);

      // Pending interrupt held while IE=0, taken once enabled
      eret = 1'b1; step();
      idle_inputs(); mtc0 = 1'b1; rd = 5'd12; wdata = 32'h0; step();
      idle_inputs(); intr = 1'b1; step(); step();
      intr = 1'b0;
      for (int i = 0; i < 5; i++) step();
      mtc0 = 1'b1; rd = 5'd12; wdata = 32'h01; step();
      idle_inputs();
      #1 chk("int_after_ie", 32'(exc_taken), 32'h1);
      step();

      // Asynchronous reset mid-handler
      rd = 5'd12;
      #2 clrn = 1'b0;
      #1 chk("midrst_status", status, 32'h0);
      chk("midrst_cause", cause, 32'h0);
      chk("midrst_epc", epc, 32'h0);
      chk("midrst_rdata", rdata, 32'h0);
      chk("midrst_pc_sel", 32'(pc_sel), 32'h0);
      model_reset();
      @(negedge clk); clrn = 1'b1;
      step();

      // Randomised traffic against the model
      for (int i = 0; i < 600; i++) begin
         int sel;
         sel     = int'($urandom_range(0, 4));
         rd      = (sel == 0) ? 5'($urandom) : 5'(12 + (sel % 3));
         mtc0    = ($urandom_range(0, 5) == 0);
         wdata   = $urandom;
         eret    = ($urandom_range(0, 7) == 0);
         ovr     = ($urandom_range(0, 6) == 0);
         unimpl  = ($urandom_range(0, 6) == 0);
         syscall = ($urandom_range(0, 6) == 0);
         pc      = $urandom;
         pc_next = $urandom;
         if ($urandom_range(0, 4) == 0) intr = ~intr;
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
      $finish;
   end

endmodule
